// File: rtl/vxe_axi_switch_arb_pkg.sv
// Shared definitions for the two-master request arbiter: request vector
// layouts, FSM state encoding and the round-robin pick helper.
package vxe_axi_switch_arb_pkg;

   localparam int TXNREQA_W = 44;
   localparam int TXNREQD_W = 72;

   // Request-address beat: rnw=1 is a read, rnw=0 a write that owes a data beat.
   typedef struct packed {
      logic        rnw;
      logic [2:0]  id;
      logic [7:0]  len;
      logic [31:0] addr;
   } txnreqa_t;

   // Write-data beat.
   typedef struct packed {
      logic [7:0]  strb;
      logic [63:0] data;
   } txnreqd_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } arb_state_e;

   // Single requester wins outright; with both requesting, the one not served last wins.
   function automatic logic arb_pick(input logic v0, input logic v1, input logic lst);
      if (v0 && v1) begin
         return ~lst;
      end
      return v1;
   endfunction

endpackage

// File: rtl/vxe_txnreqa_decoder.sv
// Field extraction for a request-address vector; the arbiter only needs rnw.
module vxe_txnreqa_decoder
   import vxe_axi_switch_arb_pkg::*;
(
   input  logic [TXNREQA_W-1:0] rqa,
   output logic                 rnw
);

   txnreqa_t fields;
   logic     unused_fields;

   assign fields        = txnreqa_t'(rqa);
   assign rnw           = fields.rnw;
   assign unused_fields = ^{fields.id, fields.len, fields.addr};

endmodule

// File: rtl/vxe_axi_switch_arb.sv
// Two-master arbiter in front of the switch upstream unit. One master owns the
// path at a time; a write keeps its grant until its data beat has gone, so
// data always follows its own address with nothing interleaved.
module vxe_axi_switch_arb
   import vxe_axi_switch_arb_pkg::*;
(
   input  logic                 clk,
   input  logic                 nrst,
   input  logic                 i_m0_rqa_vld,
   input  logic [TXNREQA_W-1:0] i_m0_rqa,
   output logic                 o_m0_rqa_rd,
   input  logic                 i_m0_rqd_vld,
   input  logic [TXNREQD_W-1:0] i_m0_rqd,
   output logic                 o_m0_rqd_rd,
   input  logic                 i_m1_rqa_vld,
   input  logic [TXNREQA_W-1:0] i_m1_rqa,
   output logic                 o_m1_rqa_rd,
   input  logic                 i_m1_rqd_vld,
   input  logic [TXNREQD_W-1:0] i_m1_rqd,
   output logic                 o_m1_rqd_rd,
   output logic                 o_s_rqa_vld,
   output logic [TXNREQA_W-1:0] o_s_rqa,
   input  logic                 i_s_rqa_rd,
   output logic                 o_s_rqd_vld,
   output logic [TXNREQD_W-1:0] o_s_rqd,
   input  logic                 i_s_rqd_rd
);

   arb_state_e           state_reg, state_next;
   logic                 gnt_reg, gnt_next;
   logic                 lst_reg, lst_next;
   logic                 sel_rqa_vld, sel_rqd_vld, other_rqa_vld, sel_rnw;
   logic [TXNREQA_W-1:0] sel_rqa;
   logic [TXNREQD_W-1:0] sel_rqd;
   logic                 in_addr, in_data, rqa_xfer, rqd_xfer;

   // Granted master's channels steered toward the upstream unit.
   assign sel_rqa_vld   = gnt_reg ? i_m1_rqa_vld : i_m0_rqa_vld;
   assign sel_rqa       = gnt_reg ? i_m1_rqa     : i_m0_rqa;
   assign sel_rqd_vld   = gnt_reg ? i_m1_rqd_vld : i_m0_rqd_vld;
   assign sel_rqd       = gnt_reg ? i_m1_rqd     : i_m0_rqd;
   assign other_rqa_vld = gnt_reg ? i_m0_rqa_vld : i_m1_rqa_vld;

   // Handshake outputs are masked while reset is asserted so nothing transfers
   // in the cycle a reset abandons an in-flight write.
   assign in_addr  = nrst && (state_reg == ST_ADDR);
   assign in_data  = nrst && (state_reg == ST_DATA);
   assign rqa_xfer = in_addr && sel_rqa_vld && i_s_rqa_rd;
   assign rqd_xfer = in_data && sel_rqd_vld && i_s_rqd_rd;

   vxe_txnreqa_decoder u_rqa_dec (
      .rqa (sel_rqa),
      .rnw (sel_rnw)
   );

   // State, grant and last-served registers.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_reg <= ST_IDLE;
         gnt_reg   <= 1'b0;
         lst_reg   <= 1'b1;
      end else begin
         state_reg <= state_next;
         gnt_reg   <= gnt_next;
         lst_reg   <= lst_next;
      end
   end

   // Next state: a finished transaction hands the path to the other master if it
   // is waiting, otherwise the arbiter goes idle.
   always_comb begin
      state_next = state_reg;
      gnt_next   = gnt_reg;
      lst_next   = lst_reg;
      case (state_reg)
         ST_IDLE: begin
            if (i_m0_rqa_vld || i_m1_rqa_vld) begin
               gnt_next   = arb_pick(i_m0_rqa_vld, i_m1_rqa_vld, lst_reg);
               state_next = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (rqa_xfer) begin
               if (sel_rnw) begin
                  lst_next = gnt_reg;
                  if (other_rqa_vld) begin
                     gnt_next = ~gnt_reg;
                  end else begin
                     state_next = ST_IDLE;
                  end
               end else begin
                  state_next = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (rqd_xfer) begin
               lst_next = gnt_reg;
               if (other_rqa_vld) begin
                  gnt_next   = ~gnt_reg;
                  state_next = ST_ADDR;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Forwarded valids/vectors and per-master accepts.
   always_comb begin
      o_s_rqa_vld = in_addr && sel_rqa_vld;
      o_s_rqa     = sel_rqa;
      o_s_rqd_vld = in_data && sel_rqd_vld;
      o_s_rqd     = sel_rqd;
      o_m0_rqa_rd = in_addr && !gnt_reg && i_s_rqa_rd;
      o_m1_rqa_rd = in_addr &&  gnt_reg && i_s_rqa_rd;
      o_m0_rqd_rd = in_data && !gnt_reg && i_s_rqd_rd;
      o_m1_rqd_rd = in_data &&  gnt_reg && i_s_rqd_rd;
   end

endmodule

// File: tb/tb_vxe_axi_switch_arb.sv
// Bench for the two-master arbiter: directed scenarios with literal
// expectations, then randomized masters checked cycle by cycle against a
// transaction-level model of who owns the path and what it still owes.
module tb_vxe_axi_switch_arb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        nrst;
   logic [1:0]  v, dv;
   logic [43:0] a [2];
   logic [71:0] d [2];
   logic        s_ard, s_drd;

   logic        s_rqa_vld, s_rqd_vld;
   logic [43:0] s_rqa;
   logic [71:0] s_rqd;
   logic [1:0]  m_rqa_rd, m_rqd_rd;

   vxe_axi_switch_arb dut (
      .clk          (clk),
      .nrst         (nrst),
      .i_m0_rqa_vld (v[0]),
      .i_m0_rqa     (a[0]),
      .o_m0_rqa_rd  (m_rqa_rd[0]),
      .i_m0_rqd_vld (dv[0]),
      .i_m0_rqd     (d[0]),
      .o_m0_rqd_rd  (m_rqd_rd[0]),
      .i_m1_rqa_vld (v[1]),
      .i_m1_rqa     (a[1]),
      .o_m1_rqa_rd  (m_rqa_rd[1]),
      .i_m1_rqd_vld (dv[1]),
      .i_m1_rqd     (d[1]),
      .o_m1_rqd_rd  (m_rqd_rd[1]),
      .o_s_rqa_vld  (s_rqa_vld),
      .o_s_rqa      (s_rqa),
      .i_s_rqa_rd   (s_ard),
      .o_s_rqd_vld  (s_rqd_vld),
      .o_s_rqd      (s_rqd),
      .i_s_rqd_rd   (s_drd)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Model: is the path held, by whom, does the holder still owe a data beat,
   // and who finished a transaction most recently.
   logic m_busy, m_owes_data, m_owner, m_last;

   logic       exp_s_rqa_vld, exp_s_rqd_vld;
   logic [1:0] exp_rqa_rd, exp_rqd_rd;

   always_comb begin
      exp_s_rqa_vld = nrst && m_busy && !m_owes_data && v[m_owner];
      exp_s_rqd_vld = nrst && m_busy &&  m_owes_data && dv[m_owner];
      exp_rqa_rd    = 2'b00;
      exp_rqd_rd    = 2'b00;
      if (nrst && m_busy && !m_owes_data && s_ard) exp_rqa_rd[m_owner] = 1'b1;
      if (nrst && m_busy &&  m_owes_data && s_drd) exp_rqd_rd[m_owner] = 1'b1;
   end

   always @(posedge clk) begin
      if (!nrst) begin
         m_busy      <= 1'b0;
         m_owes_data <= 1'b0;
         m_owner     <= 1'b0;
         m_last      <= 1'b1;
      end else if (!m_busy) begin
         if (v != 2'b00) begin
            m_busy      <= 1'b1;
            m_owes_data <= 1'b0;
            m_owner     <= (v == 2'b11) ? ~m_last : v[1];
         end
      end else if ((!m_owes_data && v[m_owner] && s_ard && a[m_owner][43]) ||
                   ( m_owes_data && dv[m_owner] && s_drd)) begin
         // Transaction complete: hand over to the other master if it waits.
         m_last      <= m_owner;
         m_owes_data <= 1'b0;
         if (v[~m_owner]) m_owner <= ~m_owner;
         else             m_busy  <= 1'b0;
      end else if (!m_owes_data && v[m_owner] && s_ard) begin
         m_owes_data <= 1'b1;
      end
   end

   logic chk_en = 1'b0;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("s_rqa_vld", s_rqa_vld, exp_s_rqa_vld);
         chk("s_rqd_vld", s_rqd_vld, exp_s_rqd_vld);
         chk("m_rqa_rd",  m_rqa_rd,  exp_rqa_rd);
         chk("m_rqd_rd",  m_rqd_rd,  exp_rqd_rd);
         if (exp_s_rqa_vld) chk("s_rqa", s_rqa, a[m_owner]);
         if (exp_s_rqd_vld) chk("s_rqd", s_rqd, d[m_owner]);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   function automatic logic [43:0] mk_rqa(input logic rd, input logic [31:0] addr);
      return {rd, 3'd0, 8'd0, addr};
   endfunction

   int  g [6];
   bit  has [2], wr [2], dph [2], acc_a [2], acc_d [2];

   initial begin
      nrst = 1'b0; v = 2'b00; dv = 2'b00; s_ard = 1'b0; s_drd = 1'b0;
      a[0] = '0; a[1] = '0; d[0] = '0; d[1] = '0;

      // Reset state
      cyc();
      chk_en = 1'b1;
      mid();
      chk("rst_rd",  {m_rqa_rd, m_rqd_rd}, 0);
      chk("rst_vld", {s_rqa_vld, s_rqd_vld}, 0);
      cyc(); nrst = 1'b1;
      mid();
      chk("idle_vld", {s_rqa_vld, s_rqd_vld, m_rqa_rd, m_rqd_rd}, 0);

      // Single m0 read at 0x100
      cyc(); v[0] = 1'b1; a[0] = mk_rqa(1'b1, 32'h100); s_ard = 1'b1; s_drd = 1'b1;
      mid(); chk("s1_idle_rd", m_rqa_rd[0], 0);
      cyc(); mid();
      chk("s1_vld", s_rqa_vld, 1);
      chk("s1_rqa", s_rqa, 44'h80000000100);
      chk("s1_m0_rd", m_rqa_rd, 2'b01);
      cyc(); v[0] = 1'b0;
      mid(); chk("s1_after", s_rqa_vld, 0);

      // Continuous reads from both masters alternate, m0 first after reset
      nrst = 1'b0; cyc(); cyc(); nrst = 1'b1;
      cyc(); v = 2'b11; a[0] = mk_rqa(1'b1, 32'h1000); a[1] = mk_rqa(1'b1, 32'h2000);
      cyc();
      for (int i = 0; i < 6; i++) begin
         mid();
         g[i] = m_rqa_rd[1] ? 1 : (m_rqa_rd[0] ? 0 : 7);
         cyc();
         a[0] = mk_rqa(1'b1, 32'h1000 + 32'(i));
         a[1] = mk_rqa(1'b1, 32'h2000 + 32'(i));
      end
      for (int i = 0; i < 6; i++) chk($sformatf("s2_gnt%0d", i), 72'(g[i]), 72'(i % 2));
      v = 2'b00;

      // m1 write while m0 read arrives: m1 addr, m1 data, then m0 addr
      nrst = 1'b0; cyc(); nrst = 1'b1; cyc();
      v[1] = 1'b1; a[1] = mk_rqa(1'b0, 32'h200); dv[1] = 1'b1; d[1] = {8'hFF, 64'hDEADBEEF};
      mid();
      cyc(); v[0] = 1'b1; a[0] = mk_rqa(1'b1, 32'h300);
      mid();
      chk("s3_a1_rqa", s_rqa, 44'h00000000200);
      chk("s3_a1_rd", m_rqa_rd, 2'b10);
      chk("s3_a1_drd", m_rqd_rd, 2'b00);
      cyc(); v[1] = 1'b0;
      mid();
      chk("s3_d1_vld", s_rqd_vld, 1);
      chk("s3_d1_rqd", s_rqd, 72'hFF00000000DEADBEEF);
      chk("s3_d1_rd", {m_rqa_rd, m_rqd_rd}, 4'b0010);
      cyc(); dv[1] = 1'b0;
      mid();
      chk("s3_a0_rqa", s_rqa, 44'h80000000300);
      chk("s3_a0_rd", m_rqa_rd, 2'b01);
      cyc();

      // Data channel stalled 5 cycles: hold, no accept pulse
      v[0] = 1'b1; a[0] = mk_rqa(1'b0, 32'h400); dv[0] = 1'b1; d[0] = {8'h0F, 64'h1234}; s_drd = 1'b0;
      cyc();
      cyc(); v[0] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         mid();
         chk("s4_hold_vld", s_rqd_vld, 1);
         chk("s4_hold_rd", {m_rqa_rd, m_rqd_rd}, 0);
         cyc();
      end
      s_drd = 1'b1;
      mid(); chk("s4_release", m_rqd_rd, 2'b01);
      cyc(); dv[0] = 1'b0;

      // Reset while in DATA; m0 wins the next dual request
      v[1] = 1'b1; a[1] = mk_rqa(1'b0, 32'h500); dv[1] = 1'b1; d[1] = {8'hAA, 64'h55}; s_drd = 1'b0;
      cyc();
      cyc(); v[1] = 1'b0;
      mid(); chk("s5_data_vld", s_rqd_vld, 1);
      cyc(); nrst = 1'b0;
      mid(); chk("s5_rst_outs", {s_rqa_vld, s_rqd_vld, m_rqa_rd, m_rqd_rd}, 0);
      cyc(); nrst = 1'b1; dv[1] = 1'b0; s_drd = 1'b1;
      v = 2'b11; a[0] = mk_rqa(1'b1, 32'h600); a[1] = mk_rqa(1'b1, 32'h700);
      mid(); chk("s5_idle_outs", {s_rqa_vld, s_rqd_vld, m_rqa_rd, m_rqd_rd}, 0);
      cyc();
      mid(); chk("s5_first", m_rqa_rd, 2'b01);
      cyc(); v = 2'b00;

      // Randomized masters against the model
      nrst = 1'b0; dv = 2'b00; cyc(); nrst = 1'b1;
      for (int n = 0; n < 2; n++) begin
         has[n] = 0; wr[n] = 0; dph[n] = 0; acc_a[n] = 0; acc_d[n] = 0;
      end
      for (int c = 0; c < 4000; c++) begin
         if (!nrst) begin
            for (int n = 0; n < 2; n++) begin
               has[n] = 0; dph[n] = 0; acc_a[n] = 0; acc_d[n] = 0;
            end
         end
         nrst = ($urandom_range(0, 499) != 0);
         for (int n = 0; n < 2; n++) begin
            if (acc_a[n]) begin
               if (wr[n]) dph[n] = 1;
               else       has[n] = 0;
            end
            if (acc_d[n]) begin
               has[n] = 0; dph[n] = 0;
            end
            if (!has[n] && $urandom_range(0, 3) != 0) begin
               has[n] = 1; dph[n] = 0; wr[n] = $urandom_range(0, 1) != 0;
               a[n] = {~wr[n], 3'($urandom), 8'($urandom), 32'($urandom)};
               d[n] = {8'($urandom), 32'($urandom), 32'($urandom)};
            end
            v[n]  = has[n] && !dph[n] && ($urandom_range(0, 7) != 0);
            dv[n] = has[n] && wr[n] && ($urandom_range(0, 3) != 0);
         end
         s_ard = $urandom_range(0, 3) != 0;
         s_drd = $urandom_range(0, 3) != 0;
         mid();
         for (int n = 0; n < 2; n++) begin
            acc_a[n] = exp_rqa_rd[n] && v[n];
            acc_d[n] = exp_rqd_rd[n] && dv[n];
         end
         cyc();
      end

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vxe_axi_switch_arb.md
VXE_AXI_SWITCH_ARB -- requirements
Module: vxe_axi_switch_arb

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 nrst  in  1  reset, synchronous, active-low.
REQ-004 i_m0_rqa_vld / i_m1_rqa_vld  in  1  master N request-address valid.
REQ-005 i_m0_rqa / i_m1_rqa  in  44  master N request-address vector, txnreqa format.
REQ-006 o_m0_rqa_rd / o_m1_rqa_rd  out  1  master N request-address accept.
REQ-007 i_m0_rqd_vld / i_m1_rqd_vld  in  1  master N write-data valid.
REQ-008 i_m0_rqd / i_m1_rqd  in  72  master N write-data vector, txnreqd format.
REQ-009 o_m0_rqd_rd / o_m1_rqd_rd  out  1  master N write-data accept.
REQ-010 o_s_rqa_vld  out  1, o_s_rqa  out  44, i_s_rqa_rd  in  1: address channel toward the switch upstream unit.
REQ-011 o_s_rqd_vld  out  1, o_s_rqd  out  72, i_s_rqd_rd  in  1: data channel toward the switch upstream unit.

Function
REQ-012 Transfer rule: a beat transfers on a channel in a cycle where vld and rd are both high at the same rising edge.
REQ-013 FSM states:
- IDLE: no grant.
- ADDR: granted master's address forwarded.
- DATA: granted master's write data forwarded.
REQ-014 Grant register gnt (0/1) and last-served pointer lst.
- Arbitration: only one master with rqa_vld -> that master; both -> master != lst.
REQ-015 IDLE: if any i_mN_rqa_vld, latch arbitration result into gnt -> ADDR next cycle; else stay IDLE.
REQ-016 ADDR on address transfer, rnw decoded from granted rqa:
- Read: lst<=gnt; if any rqa_vld is pending this cycle (excluding the beat just transferred by gnt), re-arbitrate with updated lst and stay in ADDR; else -> IDLE.
- Write: -> DATA, gnt held.
REQ-017 DATA on data transfer: lst<=gnt, then same re-arbitrate/IDLE rule as REQ-016.
REQ-018 Address channel outputs:
- o_s_rqa_vld = (state==ADDR) && i_m[gnt]_rqa_vld.
- o_s_rqa = i_m[gnt]_rqa, combinational, zero latency.
REQ-019 Data channel outputs:
- o_s_rqd_vld = (state==DATA) && i_m[gnt]_rqd_vld.
- o_s_rqd = i_m[gnt]_rqd, combinational, zero latency.
REQ-020 Accept outputs:
- o_mN_rqa_rd = (state==ADDR) && gnt==N && i_s_rqa_rd.
- o_mN_rqd_rd = (state==DATA) && gnt==N && i_s_rqd_rd.
- Non-granted master: both rd outputs held 0.
REQ-021 Data offered before its address is granted is held off (rd=0) and never reordered; a write's data beat always follows its own address with no other master's beat between.
REQ-022 i_s_rqa_rd or i_s_rqd_rd low: state and gnt hold indefinitely, no timeout.
REQ-023 Granted master drops rqa_vld in ADDR: stay in ADDR with no transfer until it returns.
REQ-024 rqd_vld in ADDR and rqa_vld in DATA are ignored.
REQ-025 Throughput: back-to-back reads sustain 1 address/cycle; a write costs 2 cycles minimum.

Reset
REQ-026 nrst low at a clock edge: state=IDLE, gnt=0, lst=1 (master 0 first), regardless of state.
REQ-027 During and after reset: all rd and vld outputs 0 until the first post-reset grant.
REQ-028 A write interrupted between address and data is abandoned; no partial beat is replayed.

Structure
REQ-029 FSM state encodings and txnreqa/txnreqd widths (44, 72) live in the shared vxe package.
REQ-030 rnw extraction instantiates the existing vxe_txnreqa_decoder on the granted rqa vector; there are no other sub-modules.

Verification
REQ-031 Required directed scenarios:
- Only m0 read, rqa=addr 0x100, s_rd=1 -> o_s_rqa equals m0 vector one cycle after vld; o_m0_rqa_rd=1 on that cycle.
- m0 and m1 continuous reads, s_rd=1 -> grants alternate 0,1,0,1 starting with m0 after reset.
- m1 write (addr 0x200, data 0xDEADBEEF, strb 0xFF) while m0 read pending -> m1 addr, then m1 data, then m0 addr; m0 rd=0 throughout.
- i_s_rqd_rd low 5 cycles in DATA -> state and gnt held, o_s_rqd_vld=1, no master rd pulse until rd high.
- nrst low in DATA -> next cycle IDLE, all rd=0; m0 wins the first subsequent dual request.
